// File: rtl/game_flow_ctrl.sv
// Game sequencer for the ball-catch game: turns button/frame/ball events into
// serve, play, miss and end-of-game phases and drives the ball and score controls.
module game_flow_ctrl #(
    parameter int LIVES         = 3,
    parameter int SERVE_FRAMES  = 60,
    parameter int SPEEDUP_EVERY = 5,
    parameter int MAX_SPEED     = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       caught,
    input  logic       missed,
    input  logic       win,
    output logic [2:0] state,
    output logic       new_game,
    output logic       ball_reset,
    output logic       ball_run,
    output logic [2:0] ball_speed,
    output logic [1:0] lives_left,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_MISSED = 3'd3,
        S_WON    = 3'd4,
        S_OVER   = 3'd5
    } state_e;

    state_e     state_q;
    logic       new_game_q;
    logic       ball_reset_q;
    logic       ball_run_q;
    logic [2:0] speed_q;
    logic [1:0] lives_q;
    logic       game_over_q;
    logic [7:0] serve_cnt_q;
    logic [3:0] catch_cnt_q;

    logic       start_q;
    logic       caught_q;
    logic       missed_q;
    logic       start_arm_q;

    logic       start_rise;
    logic       caught_rise;
    logic       missed_rise;
    logic [3:0] catch_inc;

    function automatic logic [2:0] speed_up(input logic [2:0] s);
        if (s >= 3'(MAX_SPEED))
            return 3'(MAX_SPEED);
        else
            return s + 3'd1;
    endfunction

    function automatic logic [2:0] speed_down(input logic [2:0] s);
        if (s <= 3'd1)
            return 3'd1;
        else
            return s - 3'd1;
    endfunction

    // The start history register reads 0 after reset without having seen the
    // button, so a button held through reset must first be seen released
    // (start_arm_q) before its next rise counts as a press.
    assign start_rise  = start_btn & ~start_q & start_arm_q;
    assign caught_rise = caught & ~caught_q;
    assign missed_rise = missed & ~missed_q;
    assign catch_inc   = catch_cnt_q + 4'd1;

    // Previous-cycle copies of the level inputs for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q     <= 1'b0;
            caught_q    <= 1'b0;
            missed_q    <= 1'b0;
            start_arm_q <= 1'b0;
        end else begin
            start_q     <= start_btn;
            caught_q    <= caught;
            missed_q    <= missed;
            start_arm_q <= start_arm_q | ~start_btn;
        end
    end

    // Game FSM with registered outputs and serve/catch counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            new_game_q   <= 1'b0;
            ball_reset_q <= 1'b1;
            ball_run_q   <= 1'b0;
            speed_q      <= 3'd1;
            lives_q      <= 2'd0;
            game_over_q  <= 1'b0;
            serve_cnt_q  <= 8'd0;
            catch_cnt_q  <= 4'd0;
        end else begin
            new_game_q <= 1'b0;
            case (state_q)
                S_IDLE, S_WON, S_OVER: begin
                    if (start_rise) begin
                        new_game_q   <= 1'b1;
                        lives_q      <= 2'(LIVES);
                        speed_q      <= 3'd1;
                        catch_cnt_q  <= 4'd0;
                        serve_cnt_q  <= 8'(SERVE_FRAMES);
                        ball_reset_q <= 1'b1;
                        ball_run_q   <= 1'b0;
                        game_over_q  <= 1'b0;
                        state_q      <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    if (frame_tick) begin
                        if (serve_cnt_q <= 8'd1) begin
                            serve_cnt_q  <= 8'd0;
                            ball_reset_q <= 1'b0;
                            ball_run_q   <= 1'b1;
                            state_q      <= S_PLAY;
                        end else begin
                            serve_cnt_q <= serve_cnt_q - 8'd1;
                        end
                    end
                end
                S_PLAY: begin
                    if (win) begin
                        ball_reset_q <= 1'b1;
                        ball_run_q   <= 1'b0;
                        state_q      <= S_WON;
                    end else if (caught_rise) begin
                        // A catch masks a simultaneous miss.
                        if (catch_inc == 4'(SPEEDUP_EVERY)) begin
                            catch_cnt_q <= 4'd0;
                            speed_q     <= speed_up(speed_q);
                        end else begin
                            catch_cnt_q <= catch_inc;
                        end
                    end else if (missed_rise) begin
                        ball_reset_q <= 1'b1;
                        ball_run_q   <= 1'b0;
                        if (lives_q == 2'd1) begin
                            lives_q     <= 2'd0;
                            game_over_q <= 1'b1;
                            state_q     <= S_OVER;
                        end else begin
                            lives_q <= lives_q - 2'd1;
                            state_q <= S_MISSED;
                        end
                    end
                end
                S_MISSED: begin
                    speed_q     <= speed_down(speed_q);
                    catch_cnt_q <= 4'd0;
                    serve_cnt_q <= 8'(SERVE_FRAMES);
                    state_q     <= S_SERVE;
                end
                default: begin
                    ball_reset_q <= 1'b1;
                    ball_run_q   <= 1'b0;
                    game_over_q  <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign new_game   = new_game_q;
    assign ball_reset = ball_reset_q;
    assign ball_run   = ball_run_q;
    assign ball_speed = speed_q;
    assign lives_left = lives_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: main instance with default parameters,
// plus a second instance (MAX_SPEED=2, SERVE_FRAMES=1) sharing the stimulus
// to observe the speed ceiling.
module tb_game_flow_ctrl;

    localparam int SF = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic       caught = 1'b0;
    logic       missed = 1'b0;
    logic       win = 1'b0;

    logic [2:0] state, state_b;
    logic       new_game, new_game_b;
    logic       ball_reset, ball_reset_b;
    logic       ball_run, ball_run_b;
    logic [2:0] ball_speed, ball_speed_b;
    logic [1:0] lives_left, lives_left_b;
    logic       game_over, game_over_b;

    int n_checks = 0;
    int n_pass   = 0;
    logic ng_seen;

    game_flow_ctrl #(.LIVES(3), .SERVE_FRAMES(SF), .SPEEDUP_EVERY(5), .MAX_SPEED(7)) u_dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start_btn(start_btn),
        .caught(caught), .missed(missed), .win(win),
        .state(state), .new_game(new_game), .ball_reset(ball_reset), .ball_run(ball_run),
        .ball_speed(ball_speed), .lives_left(lives_left), .game_over(game_over)
    );

    game_flow_ctrl #(.LIVES(3), .SERVE_FRAMES(1), .SPEEDUP_EVERY(5), .MAX_SPEED(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start_btn(start_btn),
        .caught(caught), .missed(missed), .win(win),
        .state(state_b), .new_game(new_game_b), .ball_reset(ball_reset_b), .ball_run(ball_run_b),
        .ball_speed(ball_speed_b), .lives_left(lives_left_b), .game_over(game_over_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
    endtask

    // Full serve from SERVE with a fresh counter: still serving after SF-1
    // ticks, playing right after tick SF.
    task automatic serve_out(input string tag);
        frames(SF - 1);
        check({tag, "_still_serve"}, state, 1);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        check({tag, "_play_state"}, state, 2);
        check({tag, "_play_run"}, ball_run, 1);
        check({tag, "_play_rst"}, ball_reset, 0);
        tick();
    endtask

    task automatic catch_one();
        caught = 1'b1;
        repeat (4) tick();
        caught = 1'b0;
        tick();
    endtask

    initial begin
        // Power-up
        repeat (3) tick();
        check("rst_state", state, 0);
        check("rst_ball_reset", ball_reset, 1);
        check("rst_ball_run", ball_run, 0);
        check("rst_speed", ball_speed, 1);
        check("rst_lives", lives_left, 0);
        check("rst_game_over", game_over, 0);
        rst_n = 1'b1;
        ng_seen = 1'b0;
        repeat (5) begin
            tick();
            ng_seen |= new_game;
        end
        check("idle_no_new_game", ng_seen, 0);
        check("idle_state", state, 0);

        // Start a game
        start_btn = 1'b1;
        tick();
        check("start_new_game", new_game, 1);
        check("start_state", state, 1);
        check("start_lives", lives_left, 3);
        check("start_ball_reset", ball_reset, 1);
        start_btn = 1'b0;
        tick();
        check("new_game_one_clk", new_game, 0);

        // Events ignored while serving
        start_btn = 1'b1;
        tick();
        check("serve_start_ignored_ng", new_game, 0);
        check("serve_start_ignored_st", state, 1);
        start_btn = 1'b0;
        tick();
        missed = 1'b1;
        tick();
        missed = 1'b0;
        caught = 1'b1;
        tick();
        caught = 1'b0;
        tick();
        check("serve_miss_ignored_st", state, 1);
        check("serve_miss_ignored_lives", lives_left, 3);
        serve_out("serve1");
        check("b_in_play", state_b, 2);

        // Catches and speed-up
        for (int c = 1; c <= 11; c++) begin
            catch_one();
            if (c == 4)  check("speed_after_4", ball_speed, 1);
            if (c == 5)  check("speed_after_5", ball_speed, 2);
            if (c == 5)  check("b_speed_after_5", ball_speed_b, 2);
            if (c == 9)  check("speed_after_9", ball_speed, 2);
            if (c == 10) check("speed_after_10", ball_speed, 3);
            if (c == 10) check("b_speed_cap_10", ball_speed_b, 2);
        end
        // Catch 12 coincides with a miss: the catch wins
        caught = 1'b1;
        missed = 1'b1;
        tick();
        check("catch_miss_state", state, 2);
        check("catch_miss_lives", lives_left, 3);
        repeat (3) tick();
        caught = 1'b0;
        missed = 1'b0;
        tick();
        check("speed_after_12", ball_speed, 3);
        for (int c = 13; c <= 35; c++) begin
            catch_one();
            if (c == 29) check("speed_after_29", ball_speed, 6);
            if (c == 30) check("speed_after_30", ball_speed, 7);
            if (c == 35) check("speed_sat_35", ball_speed, 7);
            if (c == 35) check("b_speed_sat_35", ball_speed_b, 2);
        end

        // Three misses
        missed = 1'b1;
        tick();
        check("miss1_state", state, 3);
        check("miss1_lives", lives_left, 2);
        check("miss1_run", ball_run, 0);
        check("miss1_ball_reset", ball_reset, 1);
        missed = 1'b0;
        tick();
        check("miss1_to_serve", state, 1);
        check("miss1_speed", ball_speed, 6);
        serve_out("serve2");

        missed = 1'b1;
        tick();
        check("miss2_state", state, 3);
        check("miss2_lives", lives_left, 1);
        missed = 1'b0;
        tick();
        check("miss2_to_serve", state, 1);
        check("miss2_speed", ball_speed, 5);
        serve_out("serve3");

        missed = 1'b1;
        tick();
        check("miss3_state_over", state, 5);
        check("miss3_game_over", game_over, 1);
        check("miss3_lives", lives_left, 0);
        check("miss3_run", ball_run, 0);
        check("miss3_speed", ball_speed, 5);
        missed = 1'b0;
        tick();
        check("over_holds", state, 5);

        // Restart from OVER
        start_btn = 1'b1;
        tick();
        check("over_restart_ng", new_game, 1);
        check("over_restart_state", state, 1);
        check("over_restart_lives", lives_left, 3);
        check("over_restart_go", game_over, 0);
        check("over_restart_speed", ball_speed, 1);
        start_btn = 1'b0;
        tick();
        serve_out("serve4");

        // Miss at speed 1 stays at 1
        missed = 1'b1;
        tick();
        check("floor_miss_lives", lives_left, 2);
        missed = 1'b0;
        tick();
        check("speed_floor", ball_speed, 1);
        serve_out("serve5");

        // Win beats a simultaneous miss
        win = 1'b1;
        missed = 1'b1;
        tick();
        check("win_state", state, 4);
        check("win_lives", lives_left, 2);
        check("win_run", ball_run, 0);
        missed = 1'b0;
        tick();
        check("win_holds", state, 4);
        start_btn = 1'b1;
        tick();
        check("won_restart_ng", new_game, 1);
        check("won_restart_lives", lives_left, 3);
        check("won_restart_state", state, 1);
        start_btn = 1'b0;
        win = 1'b0;
        tick();
        serve_out("serve6");

        // Asynchronous reset mid-play
        for (int c = 1; c <= 15; c++) catch_one();
        check("pre_reset_speed", ball_speed, 4);
        start_btn = 1'b1;
        tick();
        check("play_start_ignored", state, 2);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", state, 0);
        check("async_rst_ball_reset", ball_reset, 1);
        check("async_rst_run", ball_run, 0);
        check("async_rst_speed", ball_speed, 1);
        check("async_rst_lives", lives_left, 0);
        check("async_rst_go", game_over, 0);
        check("async_rst_ng", new_game, 0);
        tick();
        tick();
        rst_n = 1'b1;
        ng_seen = 1'b0;
        repeat (5) begin
            tick();
            ng_seen |= new_game;
        end
        check("held_start_no_ng", ng_seen, 0);
        check("held_start_idle", state, 0);
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
        check("fresh_start_ng", new_game, 1);
        check("fresh_start_state", state, 1);
        start_btn = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game sequencer for the ball-catch game.
- Drives the scoring block's new_game input, and the ball engine's respawn and run controls and speed level.
- Consumes the scoring block's caught/win flags, plus a miss flag from the ball engine.
- Sits between the VGA frame timing (frame_tick), the user push-button, and the ball/bar/score datapath.

Parameters:
- LIVES, 3: lives granted per game; range 1..3.
- SERVE_FRAMES, 60: frame_ticks the ball is held at the spawn point before release; range 1..255.
- SPEEDUP_EVERY, 5: catches per speed-level increase; range 1..15.
- MAX_SPEED, 7: ceiling for ball_speed; range 1..7.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- frame_tick, input, 1: one-clk pulse per video frame.
- start_btn, input, 1: start/restart button, already synchronised, level.
- caught, input, 1: level from the scoring block; high while the ball sits on the bar.
- missed, input, 1: level; high while the ball is at the bottom outside the bar.
- win, input, 1: level from the scoring block (score >= max_score).
- state, output, 3: current FSM state encoding.
- new_game, output, 1: one-clk pulse that clears the score.
- ball_reset, output, 1: hold the ball at the spawn point.
- ball_run, output, 1: enable ball motion.
- ball_speed, output, 3: speed level, 1..MAX_SPEED.
- lives_left, output, 2: remaining lives.
- game_over, output, 1: high in OVER.

Behaviour:
- Reset (rst_n low, asynchronous) sets every output and register immediately:
  - state=IDLE, new_game=0, ball_reset=1, ball_run=0, ball_speed=1, lives_left=0, game_over=0.
  - Serve counter=0, catch counter=0, edge registers=0.
  - Reset takes effect from any state, mid-serve or mid-play.
- Edge detection: start_btn, caught and missed are each registered once. Events are rising edges only (cur & ~prev).
  - A level held for many cycles counts as exactly one event.
- States and encoding: IDLE=0, SERVE=1, PLAY=2, MISSED=3, WON=4, OVER=5. Encodings 6 and 7 return to IDLE on the next clk.
- IDLE: ball_reset=1, ball_run=0.
  - On a start edge: new_game=1 for that one clk, lives_left=LIVES, ball_speed=1, catch counter=0, serve counter=SERVE_FRAMES, go to SERVE.
- SERVE: ball_reset=1, ball_run=0.
  - Each frame_tick decrements the serve counter.
  - The tick that takes it from 1 to 0 moves the FSM to PLAY. SERVE therefore lasts exactly SERVE_FRAMES ticks.
  - caught, missed and win are ignored in SERVE.
- PLAY: ball_reset=0, ball_run=1. Event priority on the same clk: win > caught edge > missed edge.
  - win high: go to WON; ball_run drops the next clk.
  - caught edge: catch counter +1. If it reaches SPEEDUP_EVERY, clear it and set ball_speed=min(ball_speed+1, MAX_SPEED); saturates, never wraps.
  - missed edge with lives_left=1: lives_left=0, go to OVER.
  - missed edge otherwise: lives_left-1, go to MISSED.
- MISSED: exactly one clk.
  - Sets ball_speed=max(ball_speed-1, 1), catch counter=0, serve counter=SERVE_FRAMES, then goes to SERVE.
  - ball_reset=1, ball_run=0.
- WON: ball_run=0, ball_reset=1.
  - On a start edge: new_game pulse (the scoring block clears score while win=1), full re-init as from IDLE, go to SERVE.
- OVER: game_over=1, ball_run=0, ball_reset=1.
  - On a start edge: same as in WON.
- Simultaneous events:
  - Start edge during SERVE or PLAY is ignored.
  - frame_tick has no effect outside SERVE.
  - A caught edge and a missed edge in the same clk: caught wins and missed is discarded.
- Latency: all outputs are registered, changing one clk after the causing input edge.

Test Plan:
- Power-up: rst_n low 3 clk, then high, no stimulus → state=0, ball_reset=1, ball_run=0, ball_speed=1, lives_left=0, new_game never pulses.
- Start edge with SERVE_FRAMES=60 → new_game high exactly 1 clk, lives_left=3, ball_reset=1. PLAY (state=2, ball_run=1) is entered on the clk after the 60th frame_tick, not on the 59th.
- In PLAY, 12 caught edges (caught held high 4 clk each), SPEEDUP_EVERY=5 → ball_speed goes 1→2 after catch 5 and 2→3 after catch 10. With MAX_SPEED=2 it stays at 2.
- Three missed edges, each followed by a full serve → lives_left 3→2→1→0, state passes MISSED→SERVE twice, then ends in OVER with game_over=1. Speed drops by 1 per miss, floored at 1.
- win high in PLAY on the same clk as a missed edge → state=WON, lives_left unchanged. A start edge then produces a new_game pulse, lives_left=3, state=SERVE.
- rst_n pulsed low mid-PLAY with ball_speed=4 → all outputs return to reset values asynchronously, before the next clk edge. A held start_btn does not restart the game without a fresh rising edge after reset.
